// File: rtl/jtpopeye_prom_loader.sv
// Colour-PROM writer for the Popeye colour mixer: decodes the ROM download stream into
// timed write strobes for PROMs 3a/4a/5a/5b. Define JTPOPEYE_PROM_CKSUM_EN to add a byte checksum.
module jtpopeye_prom_loader #(
  parameter logic [21:0] PROM_START = 22'h1_0000,
  parameter int unsigned WE_LEN     = 2
`ifdef JTPOPEYE_PROM_CKSUM_EN
  ,parameter logic [7:0] CKSUM_REF  = 8'h00
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [21:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [7:0]  prog_addr,
  output logic [7:0]  prom_din,
  output logic        prom_3a_we,
  output logic        prom_4a_we,
  output logic        prom_5a_we,
  output logic        prom_5b_we,
  output logic        prom_done,
  output logic        prom_err
`ifdef JTPOPEYE_PROM_CKSUM_EN
  ,output logic [7:0] prom_cksum
`endif
);

  localparam int unsigned  CNT_W      = 10;
  localparam logic [CNT_W-1:0] PROM_TOTAL = 10'd576;
  localparam logic [21:0]  REGION_LEN = 22'h240;

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

  state_t           state;
  logic [3:0]       we;
  logic [3:0]       we_cnt;
  logic [CNT_W-1:0] byte_cnt;
  logic             dl_q;
  logic             end_pend;
  logic             buf_full;
  logic [7:0]       buf_addr;
  logic [7:0]       buf_data;
  logic [1:0]       buf_tgt;

  logic [21:0] offset;
  logic        in_region;
  logic [1:0]  dec_tgt;
  logic [7:0]  dec_addr;
  logic        capture;
  logic        drain;
  logic        overrun;
  logic        ck_bad;

  // Region decode of the incoming download byte
  always_comb begin
    offset    = ioctl_addr - PROM_START;
    in_region = (ioctl_addr >= PROM_START) && (offset < REGION_LEN);
    dec_tgt   = 2'd0;
    dec_addr  = {3'b000, offset[4:0]};
    if (offset < 22'h20) begin
      dec_tgt = 2'd0;
    end else if (offset < 22'h40) begin
      dec_tgt = 2'd1;
    end else if (offset < 22'h140) begin
      dec_tgt  = 2'd2;
      dec_addr = 8'(offset - 22'h40);
    end else begin
      dec_tgt  = 2'd3;
      dec_addr = 8'(offset - 22'h140);
    end
  end

  assign capture = downloading && ioctl_wr && in_region;
  assign drain   = (state == IDLE) && buf_full;
  assign overrun = capture && buf_full && !drain;

`ifdef JTPOPEYE_PROM_CKSUM_EN
  assign ck_bad = (CKSUM_REF != 8'h00) && (prom_cksum != CKSUM_REF);
`else
  assign ck_bad = 1'b0;
`endif

  assign prom_3a_we = we[0];
  assign prom_4a_we = we[1];
  assign prom_5a_we = we[2];
  assign prom_5b_we = we[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      we        <= 4'd0;
      we_cnt    <= 4'd0;
      prog_addr <= 8'd0;
      prom_din  <= 8'd0;
      byte_cnt  <= '0;
      dl_q      <= 1'b0;
      end_pend  <= 1'b0;
      buf_full  <= 1'b0;
      buf_addr  <= 8'd0;
      buf_data  <= 8'd0;
      buf_tgt   <= 2'd0;
      prom_done <= 1'b0;
      prom_err  <= 1'b0;
`ifdef JTPOPEYE_PROM_CKSUM_EN
      prom_cksum <= 8'd0;
`endif
    end else begin
      dl_q <= downloading;

      case (state)
        IDLE: begin
          if (buf_full) begin
            prog_addr <= buf_addr;
            prom_din  <= buf_data;
            we        <= 4'b0001 << buf_tgt;
            we_cnt    <= 4'd0;
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (we_cnt == 4'(WE_LEN - 1)) begin
            we    <= 4'd0;
            state <= HOLD;
            if (byte_cnt != PROM_TOTAL) byte_cnt <= byte_cnt + 10'd1;
`ifdef JTPOPEYE_PROM_CKSUM_EN
            prom_cksum <= prom_cksum + prom_din;
`endif
          end else begin
            we_cnt <= we_cnt + 4'd1;
          end
        end
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // One-entry skid buffer; a drain frees the slot for a same-cycle capture
      if (capture && (!buf_full || drain)) begin
        buf_full <= 1'b1;
        buf_addr <= dec_addr;
        buf_data <= ioctl_data;
        buf_tgt  <= dec_tgt;
      end else if (drain) begin
        buf_full <= 1'b0;
      end

      // Download bracketing: start clears status, end waits for the pipe to empty
      if (downloading && !dl_q) begin
        byte_cnt  <= '0;
        prom_done <= 1'b0;
        prom_err  <= 1'b0;
        end_pend  <= 1'b0;
`ifdef JTPOPEYE_PROM_CKSUM_EN
        prom_cksum <= 8'd0;
`endif
      end else if (!downloading && dl_q) begin
        end_pend <= 1'b1;
      end else if (end_pend && (state == IDLE) && !buf_full) begin
        end_pend <= 1'b0;
        if (prom_err || (byte_cnt != PROM_TOTAL) || ck_bad) prom_err  <= 1'b1;
        else                                                 prom_done <= 1'b1;
      end

      if (overrun) prom_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtpopeye_prom_loader.sv
// Scoreboard bench for jtpopeye_prom_loader: random download streams against a region-rule
// reference model; a negedge monitor pops expected PROM writes as strobes appear.
module tb_jtpopeye_prom_loader;

  localparam logic [21:0] PROM_START = 22'h1_0000;
  localparam int unsigned WE_LEN     = 2;
  localparam logic [7:0]  CK_REF     = 8'h5A;
`ifdef JTPOPEYE_PROM_CKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        downloading;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic [7:0]  prog_addr;
  logic [7:0]  prom_din;
  logic        prom_3a_we, prom_4a_we, prom_5a_we, prom_5b_we;
  logic        prom_done, prom_err;
`ifdef JTPOPEYE_PROM_CKSUM_EN
  logic [7:0]  prom_cksum;
`endif

  jtpopeye_prom_loader #(
    .PROM_START (PROM_START),
    .WE_LEN     (WE_LEN)
`ifdef JTPOPEYE_PROM_CKSUM_EN
    ,.CKSUM_REF (CK_REF)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_data  (ioctl_data),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prom_din    (prom_din),
    .prom_3a_we  (prom_3a_we),
    .prom_4a_we  (prom_4a_we),
    .prom_5a_we  (prom_5a_we),
    .prom_5b_we  (prom_5b_we),
    .prom_done   (prom_done),
    .prom_err    (prom_err)
`ifdef JTPOPEYE_PROM_CKSUM_EN
    ,.prom_cksum (prom_cksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] tgt;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         n_wr;
  logic [7:0] sum;
  bit         ovr;
  int         tally[4];
  logic [7:0] dat[576];
  int         order[576];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which PROM and address a download byte lands in
  function automatic bit decode(input logic [21:0] a, input logic [7:0] d, output wr_t w);
    int off;
    int base;
    off = int'(a) - int'(PROM_START);
    w   = '0;
    if (off < 0 || off >= 576) return 1'b0;
    if (off < 32)       begin w.tgt = 2'd0; base = 0;   end
    else if (off < 64)  begin w.tgt = 2'd1; base = 32;  end
    else if (off < 320) begin w.tgt = 2'd2; base = 64;  end
    else                begin w.tgt = 2'd3; base = 320; end
    w.addr = 8'(off - base);
    w.data = d;
    return 1'b1;
  endfunction

  function automatic int we_idx(input logic [3:0] w);
    case (w)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 7;
    endcase
  endfunction

  // Drive one byte at a negedge; acc=0 marks a byte the model knows must be dropped
  task automatic send(input logic [21:0] a, input logic [7:0] d, input int gap, input bit acc);
    wr_t w;
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    if (downloading && decode(a, d, w)) begin
      if (acc) begin
        exp_q.push_back(w);
        if (n_wr < 576) n_wr++;
        sum = sum + d;
      end else begin
        ovr = 1'b1;
      end
    end
    @(negedge clk);
    if (gap > 1) begin
      ioctl_wr = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic dl_start();
    @(negedge clk);
    downloading = 1'b1;
    n_wr = 0;
    sum  = 8'd0;
    ovr  = 1'b0;
    for (int i = 0; i < 4; i++) tally[i] = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic dl_end(input string name);
    int  t;
    bit  exp_done;
    @(negedge clk);
    ioctl_wr    = 1'b0;
    downloading = 1'b0;
    t = 0;
    while (!(prom_done || prom_err) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no done/err after %0d cycles", name, t);
    end
    exp_done = (n_wr == 576) && !ovr && (!CK_EN || CK_REF == 8'h00 || sum == CK_REF);
    chk({name, "_done"}, 32'(prom_done), 32'(exp_done));
    chk({name, "_err"},  32'(prom_err),  32'(!exp_done));
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
`ifdef JTPOPEYE_PROM_CKSUM_EN
    chk({name, "_cksum"}, 32'(prom_cksum), 32'(sum));
`endif
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_prog_addr"}, 32'(prog_addr), 32'd0);
    chk({name, "_prom_din"},  32'(prom_din),  32'd0);
    chk({name, "_we"}, 32'({prom_5b_we, prom_5a_we, prom_4a_we, prom_3a_we}), 32'd0);
    chk({name, "_done"}, 32'(prom_done), 32'd0);
    chk({name, "_err"},  32'(prom_err),  32'd0);
`ifdef JTPOPEYE_PROM_CKSUM_EN
    chk({name, "_cksum"}, 32'(prom_cksum), 32'd0);
`endif
  endtask

  // Monitor: one expected entry per strobe pulse; width and hold stability checked
  logic [3:0] we_now;
  logic [3:0] prev_we = 4'd0;
  int         hi_cnt  = 0;
  logic [7:0] la, ld;
  assign we_now = {prom_5b_we, prom_5a_we, prom_4a_we, prom_3a_we};

  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      prev_we = 4'd0;
      hi_cnt  = 0;
    end else begin
      if (we_now != 4'd0 && prev_we == 4'd0) begin
        chk("onehot", 32'(we_idx(we_now) < 4), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: we=%b addr=%0h data=%0h", we_now, prog_addr, prom_din);
        end else begin
          e = exp_q.pop_front();
          chk("wr_target", 32'(we_idx(we_now)), 32'(e.tgt));
          chk("wr_addr", 32'(prog_addr), 32'(e.addr));
          chk("wr_data", 32'(prom_din), 32'(e.data));
          if (we_idx(we_now) < 4) tally[we_idx(we_now)]++;
        end
        la     = prog_addr;
        ld     = prom_din;
        hi_cnt = 1;
      end else if (we_now != 4'd0) begin
        hi_cnt++;
        chk("we_stable", 32'(we_now), 32'(prev_we));
        chk("addr_stable", 32'(prog_addr), 32'(la));
        chk("data_stable", 32'(prom_din), 32'(ld));
      end else if (prev_we != 4'd0) begin
        chk("we_len", 32'(hi_cnt), 32'(WE_LEN));
        chk("hold_addr", 32'(prog_addr), 32'(la));
        chk("hold_data", 32'(prom_din), 32'(ld));
      end
      prev_we = we_now;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    int         j;
    int         tmp;
    logic [7:0] s;
    rst = 1'b1;
    downloading = 1'b0;
    ioctl_addr = 22'd0;
    ioctl_data = 8'd0;
    ioctl_wr = 1'b0;
    n_wr = 0;
    sum = 8'd0;
    ovr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Full sequential load, data = offset
    dl_start();
    for (int i = 0; i < 576; i++) send(PROM_START + 22'(i), 8'(i), 8, 1'b1);
    dl_end("full_seq");
    chk("tally_3a", 32'(tally[0]), 32'd32);
    chk("tally_4a", 32'(tally[1]), 32'd32);
    chk("tally_5a", 32'(tally[2]), 32'd256);
    chk("tally_5b", 32'(tally[3]), 32'd256);

    // Region edges: only five in-range bytes written, load is short
    dl_start();
    send(PROM_START - 22'd1,   8'(($urandom)), 8, 1'b1);
    send(PROM_START + 22'h1F,  8'(($urandom)), 8, 1'b1);
    send(PROM_START + 22'h20,  8'(($urandom)), 8, 1'b1);
    send(PROM_START + 22'h13F, 8'(($urandom)), 8, 1'b1);
    send(PROM_START + 22'h140, 8'(($urandom)), 8, 1'b1);
    send(PROM_START + 22'h23F, 8'(($urandom)), 8, 1'b1);
    send(PROM_START + 22'h240, 8'(($urandom)), 8, 1'b1);
    dl_end("edges");
    chk("edges_count", 32'(tally[0] + tally[1] + tally[2] + tally[3]), 32'd5);

    // Back-to-back: two consecutive bytes accepted, third overruns
    dl_start();
    send(PROM_START + 22'(($urandom_range(0, 575))), 8'(($urandom)), 1, 1'b1);
    send(PROM_START + 22'(($urandom_range(0, 575))), 8'(($urandom)), 1, 1'b1);
    send(PROM_START + 22'(($urandom_range(0, 575))), 8'(($urandom)), 1, 1'b0);
    ioctl_wr = 1'b0;
    repeat (20) @(negedge clk);
    chk("b2b_err_sticky", 32'(prom_err), 32'd1);
    dl_end("b2b");

    // Short load: 575 random bytes
    dl_start();
    for (int i = 0; i < 575; i++) send(PROM_START + 22'(i), 8'($urandom), 6, 1'b1);
    dl_end("short");

    // Reset during a write strobe
    dl_start();
    send(PROM_START + 22'(($urandom_range(0, 575))), 8'($urandom), 1, 1'b1);
    ioctl_wr = 1'b0;
    lat = 0;
    while (we_now == 4'd0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd1);
    #1;
    rst = 1'b1;
    downloading = 1'b0;
    @(posedge clk);
    #1;
    chk_idle_outputs("rst_mid");
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();

    // Full load in random order with random data and gaps
    for (int i = 0; i < 576; i++) begin
      order[i] = i;
      dat[i] = 8'($urandom);
    end
    for (int i = 575; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    dl_start();
    for (int i = 0; i < 576; i++)
      send(PROM_START + 22'(order[i]), dat[order[i]], int'($urandom_range(6, 10)), 1'b1);
    dl_end("full_rand");

    // Load whose byte sum equals CK_REF, then the same with one byte altered
    s = 8'd0;
    for (int i = 0; i < 575; i++) begin
      dat[i] = 8'($urandom);
      s = s + dat[i];
    end
    dat[575] = CK_REF - s;
    dl_start();
    for (int i = 0; i < 576; i++) send(PROM_START + 22'(i), dat[i], 6, 1'b1);
    dl_end("cksum_good");
    dat[100] = dat[100] + 8'd1;
    dl_start();
    for (int i = 0; i < 576; i++) send(PROM_START + 22'(i), dat[i], 6, 1'b1);
    dl_end("cksum_bad");

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
